// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA pixel-tick divider, h/v counters and sync/blanking decode
// Optional frame counter output enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  output logic        p_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        frame_start
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_wrap;

  // Next counter values; sync/blank outputs decode these so they land on the same edge as x/y
  always_comb begin
    h_wrap     = (x == H_LAST);
    v_wrap     = (y == V_LAST);
    frame_wrap = p_tick && h_wrap && v_wrap;
    h_next     = x;
    v_next     = y;
    if (p_tick) begin
      h_next = h_wrap ? 10'd0 : x + 10'd1;
      if (h_wrap) begin
        v_next = v_wrap ? 10'd0 : y + 10'd1;
      end
    end
  end

  // Pixel divider, counters and registered sync/blanking outputs
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      div         <= '0;
      p_tick      <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      p_tick      <= (div == DIV_LAST);
      x           <= h_next;
      y           <= v_next;
      hsync       <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync       <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
      video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  // Completed-frame counter, bumped on the same edge that frame_start rises
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (frame_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen (reduced geometry)
module tb_vga_sync_gen;

  localparam int CD = 4;
  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VD = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int LINE  = HT * CD;
  localparam int FRAME = LINE * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int total = 0;
  int bad = 0;

  vga_sync_gen #(
    .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({x, y, hsync, vsync, video_on, p_tick, frame_start} !== {10'd0, 10'd0, 5'b11000}) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want 0 0 1 1 0 0 0",
                 i, x, y, hsync, vsync, video_on, p_tick, frame_start);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= CD + 1; i++) begin
      tick();
      if (i == 1) begin
        total++;
        if (video_on !== 1'b1) begin
          bad++;
          $display("FAIL reset_video_on: got %b want 1", video_on);
        end
      end
      total++;
      if (p_tick !== (i == CD)) begin
        bad++;
        $display("FAIL reset_first_tick clk%0d: p_tick=%b want %b", i, p_tick, (i == CD));
      end
    end
    total++;
    if (x !== 10'd1) begin
      bad++;
      $display("FAIL reset_first_x: x=%0d want 1", x);
    end
  endtask

  task automatic test_line();
    int t0 = -1, t1 = -1, hs_start_x = -1, hs_len = 0, vo_drop_x = -1, xmax = 0;
    bit in_low = 0, hs_done = 0;
    logic [9:0] prev_x;
    logic prev_hs, prev_vo;
    do_reset();
    prev_x = x; prev_hs = hsync; prev_vo = video_on;
    for (int c = 0; c < 4 * LINE; c++) begin
      tick();
      if (x == 0 && prev_x != 0) begin
        if (t0 < 0) t0 = c;
        else if (t1 < 0) t1 = c;
      end
      if (!hsync && prev_hs && hs_start_x < 0) begin
        hs_start_x = x;
        in_low = 1;
      end
      if (in_low && !hs_done) begin
        if (!hsync) hs_len++;
        else hs_done = 1;
      end
      if (!video_on && prev_vo && vo_drop_x < 0) vo_drop_x = x;
      if (x > xmax) xmax = x;
      prev_x = x; prev_hs = hsync; prev_vo = video_on;
    end
    total++;
    if (t1 - t0 != LINE) begin
      bad++;
      $display("FAIL line_period: got %0d clocks want %0d", t1 - t0, LINE);
    end
    total++;
    if (hs_start_x != HD + HF) begin
      bad++;
      $display("FAIL hsync_start_x: got %0d want %0d", hs_start_x, HD + HF);
    end
    total++;
    if (hs_len != HS * CD) begin
      bad++;
      $display("FAIL hsync_width: got %0d clocks want %0d", hs_len, HS * CD);
    end
    total++;
    if (vo_drop_x != HD) begin
      bad++;
      $display("FAIL video_drop_x: got %0d want %0d", vo_drop_x, HD);
    end
    total++;
    if (xmax != HT - 1) begin
      bad++;
      $display("FAIL x_max: got %0d want %0d", xmax, HT - 1);
    end
  endtask

  task automatic test_frame();
    int vs_start_y = -1, vs_len = 0, viol = 0, f0 = -1, f1 = -1, fs_run = 0, fs_max = 0, ymax = 0;
    bit in_low = 0, vs_done = 0;
    logic prev_vs, prev_fs;
    do_reset();
    prev_vs = vsync; prev_fs = frame_start;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (!vsync && prev_vs && vs_start_y < 0) begin
        vs_start_y = y;
        in_low = 1;
      end
      if (in_low && !vs_done) begin
        if (!vsync) vs_len++;
        else vs_done = 1;
      end
      if (video_on !== ((x < HD) && (y < VD))) viol++;
      if (frame_start && !prev_fs) begin
        if (f0 < 0) f0 = c;
        else if (f1 < 0) f1 = c;
      end
      if (frame_start) fs_run++;
      else fs_run = 0;
      if (fs_run > fs_max) fs_max = fs_run;
      if (y > ymax) ymax = y;
      prev_vs = vsync; prev_fs = frame_start;
    end
    total++;
    if (vs_start_y != VD + VF) begin
      bad++;
      $display("FAIL vsync_start_y: got %0d want %0d", vs_start_y, VD + VF);
    end
    total++;
    if (vs_len != VS * LINE) begin
      bad++;
      $display("FAIL vsync_width: got %0d clocks want %0d", vs_len, VS * LINE);
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL video_on_region: %0d clocks disagree with x/y window, want 0", viol);
    end
    total++;
    if (f1 - f0 != FRAME) begin
      bad++;
      $display("FAIL frame_period: got %0d clocks want %0d", f1 - f0, FRAME);
    end
    total++;
    if (fs_max != 1) begin
      bad++;
      $display("FAIL frame_start_width: got %0d want 1", fs_max);
    end
    total++;
    if (ymax != VT - 1) begin
      bad++;
      $display("FAIL y_max: got %0d want %0d", ymax, VT - 1);
    end
  endtask

  task automatic test_wrap();
    bit found = 0;
    do_reset();
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      if (x == HT - 1 && y == VT - 1 && p_tick) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wrap_reach: corner not seen, got 0 want 1");
    end else begin
      tick();
      if ({x, y, frame_start, video_on, vsync} !== {10'd0, 10'd0, 3'b111}) begin
        bad++;
        $display("FAIL wrap_corner: x=%0d y=%0d fs=%b vo=%b vs=%b want 0 0 1 1 1",
                 x, y, frame_start, video_on, vsync);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    do_reset();
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      if (x == HD + HF + 1 && y == 2) found = 1;
    end
    total++;
    if (!found || hsync !== 1'b0) begin
      bad++;
      $display("FAIL midreset_pre: found=%b hsync=%b want 1 0", found, hsync);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({x, y, hsync, video_on, p_tick, frame_start} !== {10'd0, 10'd0, 4'b1000}) begin
      bad++;
      $display("FAIL midreset_state: x=%0d y=%0d hs=%b vo=%b pt=%b fs=%b want 0 0 1 0 0 0",
               x, y, hsync, video_on, p_tick, frame_start);
    end
    for (int i = 1; i <= CD + 1; i++) begin
      tick();
      total++;
      if (p_tick !== (i == CD) || video_on !== 1'b1 || x !== ((i == CD + 1) ? 10'd1 : 10'd0)) begin
        bad++;
        $display("FAIL midreset_restart clk%0d: pt=%b vo=%b x=%0d want pt=%b vo=1 x=%0d",
                 i, p_tick, video_on, x, (i == CD), (i == CD + 1) ? 1 : 0);
      end
    end
  endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
  task automatic test_frame_count();
    bit seen;
    do_reset();
    total++;
    if (frame_count !== 16'd0) begin
      bad++;
      $display("FAIL fcnt_reset: got %0d want 0", frame_count);
    end
    for (int k = 1; k <= 3; k++) begin
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
        tick();
        if (frame_start) seen = 1;
      end
      total++;
      if (!seen || frame_count !== 16'(k)) begin
        bad++;
        $display("FAIL fcnt_step%0d: seen=%b count=%0d want 1 %0d", k, seen, frame_count, k);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_reset_mid();
`ifdef VGA_SYNC_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
